// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the bus memory responder: FSM states, tag layout
// and line-burst geometry.
package bus_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WDATA,
      ST_RLAT,
      ST_RBURST
   } state_e;

   // Tag layout: [12] read/write, [11:8] type, [7:0] id
   localparam int unsigned TAG_RW_BIT   = 12;
   localparam int unsigned TAG_TYPE_LSB = 8;
   localparam int unsigned TAG_TYPE_W   = 4;
   localparam int unsigned TAG_ID_LSB   = 0;
   localparam int unsigned TAG_ID_W     = 8;

   localparam logic TAG_READ  = 1'b1;
   localparam logic TAG_WRITE = 1'b0;

   localparam int unsigned BURST_BEATS = 8;

endpackage

// File: rtl/bus_mem_responder_array.sv
// Backing store: single-port synchronous RAM with a one-cycle registered read.
module bus_mem_array #(
   parameter int unsigned MEM_WORDS  = 4096,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                         clk_i,
   input  logic                         we_i,
   input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]        wdata_i,
   output logic [DATA_WIDTH-1:0]        rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Line-burst memory responder: accepts a header, then streams 8 write beats in
// or 8 read beats out, critical word first with wrap inside the 64-byte line.
module bus_mem_responder
   import bus_mem_responder_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned MEM_WORDS      = 4096,
   parameter int unsigned READ_LATENCY   = 4,
   parameter int unsigned BURST_BEATS    = bus_mem_responder_pkg::BURST_BEATS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack,
   output logic                      busy
);

   localparam int unsigned AW     = $clog2(MEM_WORDS);
   localparam int unsigned BEAT_W = $clog2(BURST_BEATS);
   localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LATENCY - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

   state_e                   state_q, state_d;
   logic [LAT_W-1:0]         lat_q, lat_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic [BEAT_W-1:0]        idx_q, idx_d;
   logic [AW-BEAT_W-1:0]     line_q, line_d;
   logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;

   logic                      mem_we;
   logic [AW-1:0]             mem_addr;
   logic [BUS_DATA_WIDTH-1:0] mem_rdata;
   logic [BEAT_W-1:0]         addr_beat;
   logic [BEAT_W-1:0]         addr_off;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         lat_q   <= '0;
         beat_q  <= '0;
         idx_q   <= '0;
         line_q  <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         line_q  <= line_d;
         tag_q   <= tag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      beat_d     = beat_q;
      idx_d      = idx_q;
      line_d     = line_q;
      tag_d      = tag_q;
      mem_we     = 1'b0;
      addr_beat  = beat_q;
      bus_reqack = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus_reqack = bus_reqcyc && reset;
            if (bus_reqack) begin
               tag_d  = bus_reqtag;
               idx_d  = bus_req[3 +: BEAT_W];
               line_d = bus_req[3 + BEAT_W +: AW - BEAT_W];
               beat_d = '0;
               if (bus_reqtag[TAG_RW_BIT] == TAG_READ) begin
                  state_d = ST_RLAT;
                  lat_d   = LAT_INIT;
               end else begin
                  state_d = ST_WDATA;
               end
            end
         end
         ST_WDATA: begin
            bus_reqack = bus_reqcyc && reset;
            if (bus_reqack) begin
               mem_we = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_RLAT: begin
            addr_beat = '0;
            if (lat_q == '0) begin
               state_d = ST_RBURST;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_RBURST: begin
            if (bus_respack) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
            // Prefetch the beat that will be on the bus next cycle (re-reads on stall)
            addr_beat = beat_d;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      addr_off = idx_q + addr_beat;
      mem_addr = {line_q, addr_off};
   end

   assign bus_respcyc = (state_q == ST_RBURST);
   assign bus_resp    = bus_respcyc ? mem_rdata : '0;
   assign bus_resptag = bus_respcyc ? tag_q : '0;
   assign busy        = (state_q != ST_IDLE);

   bus_mem_array #(
      .MEM_WORDS  (MEM_WORDS),
      .DATA_WIDTH (BUS_DATA_WIDTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (bus_req),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a line-level memory model predicts
// every read beat; a negedge compare process checks beats against it.
module tb_bus_mem_responder;

   localparam int unsigned MEM_WORDS    = 4096;
   localparam int unsigned READ_LATENCY = 4;
   localparam int unsigned BEATS        = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        bus_respack;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] model_mem [MEM_WORDS];
   logic [63:0] exp_data [$];
   logic [12:0] exp_tag  [$];
   logic [63:0] got      [$];

   always #5 clk = ~clk;

   bus_mem_responder #(
      .BUS_DATA_WIDTH (64),
      .BUS_TAG_WIDTH  (13),
      .MEM_WORDS      (MEM_WORDS),
      .READ_LATENCY   (READ_LATENCY),
      .BURST_BEATS    (BEATS)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack),
      .busy        (busy)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Word address of beat b for a header address: critical word first, wrap in line
   function automatic int unsigned beat_word(input logic [63:0] addr, input int unsigned b);
      int unsigned w;
      w = int'((addr >> 3) % MEM_WORDS);
      return (w & ~32'd7) | ((w + b) & 32'd7);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus_respcyc) begin
            if (exp_data.size() == 0) begin
               chk("resp_unexpected", 64'd1, 64'd0);
            end else begin
               chk("resp_data", bus_resp, exp_data[0]);
               chk("resp_tag", 64'(bus_resptag), 64'(exp_tag[0]));
               if (bus_respack) begin
                  got.push_back(bus_resp);
                  void'(exp_data.pop_front());
                  void'(exp_tag.pop_front());
               end
            end
         end
      end
   end

   task automatic write_line(input logic [63:0] addr, input logic [12:0] tag,
                             input logic [63:0] start, input logic [63:0] step, input int gap_beat);
      logic [63:0] d;
      @(posedge clk); #1;
      bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
      @(negedge clk);
      chk("wr_hdr_ack", 64'(bus_reqack), 64'd1);
      chk("wr_hdr_busy", 64'(busy), 64'd0);
      for (int b = 0; b < int'(BEATS); b++) begin
         @(posedge clk); #1;
         if (b == gap_beat) begin
            bus_reqcyc = 1'b0;
            @(negedge clk);
            chk("wr_gap_ack", 64'(bus_reqack), 64'd0);
            chk("wr_gap_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
         end
         d = start + step * 64'(b);
         bus_reqcyc = 1'b1; bus_req = d;
         model_mem[beat_word(addr, b)] = d;
         @(negedge clk);
         chk("wr_beat_ack", 64'(bus_reqack), 64'd1);
         if (b == int'(BEATS) - 1) chk("wr_last_busy", 64'(busy), 64'd1);
      end
      @(posedge clk); #1;
      bus_reqcyc = 1'b0;
      @(negedge clk);
      chk("wr_done_busy", 64'(busy), 64'd0);
   endtask

   task automatic read_line(input logic [63:0] addr, input logic [12:0] tag,
                            input int stall_beat, input int stall_len, input int abort_beat,
                            input bit hold_next, input logic [63:0] next_addr,
                            input logic [12:0] next_tag, input bit pre);
      int cyc, acked, scnt;
      bit first, aborted;
      cyc = 0; acked = 0; scnt = 0; first = 0; aborted = 0;
      got.delete();
      for (int b = 0; b < int'(BEATS); b++) begin
         exp_data.push_back(model_mem[beat_word(addr, b)]);
         exp_tag.push_back(tag);
      end
      if (!pre) begin
         @(posedge clk); #1;
         bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
      end
      bus_respack = 1'b1;
      @(negedge clk);
      chk("rd_hdr_ack", 64'(bus_reqack), 64'd1);
      chk("rd_hdr_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      bus_reqcyc = 1'b0;
      while (acked < int'(BEATS) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus_respcyc && !first) begin
            first = 1;
            chk("rd_latency", 64'(cyc), 64'(READ_LATENCY + 1));
         end
         if (hold_next && bus_reqcyc) chk("rd_hold_noack", 64'(bus_reqack), 64'd0);
         if (bus_respcyc && bus_respack) acked++;
         @(posedge clk); #1;
         if (abort_beat >= 0 && acked == abort_beat) begin
            aborted = 1;
            rst_n = 1'b0;
            #1;
            chk("abort_respcyc", 64'(bus_respcyc), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            exp_data.delete();
            exp_tag.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            break;
         end
         if (hold_next && first && !bus_reqcyc) begin
            bus_reqcyc = 1'b1; bus_req = next_addr; bus_reqtag = next_tag;
         end
         bus_respack = !(acked == stall_beat && scnt < stall_len);
         if (!bus_respack) scnt++;
      end
      if (!aborted) begin
         if (acked < int'(BEATS)) chk("rd_timeout", 64'(acked), 64'(BEATS));
         chk("rd_left", 64'(exp_data.size()), 64'd0);
         chk("rd_count", 64'(got.size()), 64'(BEATS));
         if (!hold_next) begin
            @(negedge clk);
            chk("rd_done_respcyc", 64'(bus_respcyc), 64'd0);
            chk("rd_done_busy", 64'(busy), 64'd0);
         end
      end
   endtask

   task automatic chk_got(input string name, input logic [63:0] lit [8]);
      for (int i = 0; i < int'(BEATS); i++) chk(name, got[i], lit[i]);
   endtask

   logic [63:0] lit [8];

   initial begin
      rst_n = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus_reqcyc = 1'b1;
      @(negedge clk);
      chk("rst_reqack", 64'(bus_reqack), 64'd0);
      chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp", bus_resp, 64'd0);
      chk("rst_resptag", 64'(bus_resptag), 64'd0);
      bus_reqcyc = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      write_line(64'h1000, 13'h0005, 64'h11, 64'h11, -1);
      read_line(64'h1000, 13'h1005, -1, 0, -1, 0, '0, '0, 0);
      lit = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
      chk_got("lit_rd_1000", lit);

      read_line(64'h1028, 13'h1123, -1, 0, -1, 0, '0, '0, 0);
      lit = '{64'h66, 64'h77, 64'h88, 64'h11, 64'h22, 64'h33, 64'h44, 64'h55};
      chk_got("lit_rd_1028", lit);

      // start index 7 with a bubble; 0xA005 aliases 0x2000 (wrap + low bits ignored)
      write_line(64'h2038, 13'h0A07, 64'hA0, 64'h1, 3);
      read_line(64'hA005, 13'h1F42, 2, 3, -1, 0, '0, '0, 0);
      lit = '{64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7, 64'hA0};
      chk_got("lit_rd_stall", lit);

      read_line(64'h1000, 13'h1001, -1, 0, -1, 1, 64'h2000, 13'h1002, 0);
      read_line(64'h2000, 13'h1002, -1, 0, -1, 0, '0, '0, 1);

      read_line(64'h1000, 13'h1003, -1, 0, 3, 0, '0, '0, 0);
      read_line(64'h1000, 13'h1004, -1, 0, -1, 0, '0, '0, 0);
      lit = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
      chk_got("lit_rd_after_abort", lit);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
